// File: rtl/llm_gather_pkg.sv
// Shared types for the mixed-precision gather path.
// Holds the FP16 container, the magnitude width and the outlier scheduler states.
package llm_gather_pkg;

    typedef logic [15:0] fp16_t;

    localparam int FP16_MAG_W = 15;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } outlier_state_e;

endpackage : llm_gather_pkg

// File: rtl/fp16_comparator.sv
// Combinational FP16 magnitude compare against a fixed threshold.
// Only the magnitude bits are taken, so the test is |x| > threshold.
module fp16_comparator
    import llm_gather_pkg::*;
#(
    parameter logic [FP16_MAG_W-1:0] THRES_MAG = 15'h4F80
) (
    input  logic [FP16_MAG_W-1:0] mag,
    output logic [0:0]            flag
);

    // Positive FP16 encodings order like unsigned integers; Inf/NaN sit above every finite value
    always_comb begin
        if (mag > THRES_MAG) begin
            flag = 1'b1;
        end else begin
            flag = 1'b0;
        end
    end

endmodule : fp16_comparator

// File: rtl/outlier_mask_scheduler.sv
// Accumulates per-column FP16 outlier flags over a ROWS-row tile and emits the
// sticky column mask plus its popcount on a valid/ready result port.
module outlier_mask_scheduler
    import llm_gather_pkg::*;
#(
    parameter int                    IN_WIDTH  = 16,
    parameter int                    IN_SIZE   = 4,
    parameter int                    ROWS      = 8,
    parameter logic [FP16_MAG_W-1:0] THRES_MAG = 15'h4F80,
    parameter int                    CNT_W     = $clog2(IN_SIZE + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [IN_SIZE-1:0][IN_WIDTH-1:0] data_in,
    input  logic                             data_in_valid,
    output logic                             data_in_ready,
    input  logic                             flush,
    output logic [IN_SIZE-1:0]               mask_out,
    output logic [CNT_W-1:0]                 outlier_count,
    output logic                             mask_out_valid,
    input  logic                             mask_out_ready
);

    localparam int              RC_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RC_W-1:0] LAST_ROW = RC_W'(ROWS - 1);

    if (IN_WIDTH != 16) begin : g_width_check
        $error("outlier_mask_scheduler: IN_WIDTH must be 16 (FP16 only)");
    end
    if (ROWS < 1) begin : g_rows_check
        $error("outlier_mask_scheduler: ROWS must be at least 1");
    end

    function automatic logic [CNT_W-1:0] popcount(input logic [IN_SIZE-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < IN_SIZE; i++) begin
            cnt = cnt + CNT_W'(vec[i]);
        end
        return cnt;
    endfunction

    logic [IN_SIZE-1:0] flag_s;
    outlier_state_e     state_r, state_nxt_s;
    logic [IN_SIZE-1:0] acc_r, acc_nxt_s;
    logic [RC_W-1:0]    row_cnt_r, row_cnt_nxt_s;
    logic [IN_SIZE-1:0] mask_r, mask_nxt_s;
    logic [CNT_W-1:0]   count_r, count_nxt_s;
    logic               valid_r;

    for (genvar j = 0; j < IN_SIZE; j++) begin : g_lane
        fp16_comparator #(
            .THRES_MAG (THRES_MAG)
        ) u_cmp (
            .mag  (data_in[j][FP16_MAG_W-1:0]),
            .flag (flag_s[j])
        );
    end

    // Next-state decode; flush beats a same-cycle beat, and EMIT only waits for the sink
    always_comb begin
        state_nxt_s   = state_r;
        acc_nxt_s     = acc_r;
        row_cnt_nxt_s = row_cnt_r;
        mask_nxt_s    = mask_r;
        count_nxt_s   = count_r;
        case (state_r)
            ACCUM: begin
                if (flush) begin
                    acc_nxt_s     = {IN_SIZE{1'b0}};
                    row_cnt_nxt_s = {RC_W{1'b0}};
                end else if (data_in_valid) begin
                    if (row_cnt_r == LAST_ROW) begin
                        mask_nxt_s    = acc_r | flag_s;
                        count_nxt_s   = popcount(acc_r | flag_s);
                        acc_nxt_s     = {IN_SIZE{1'b0}};
                        row_cnt_nxt_s = {RC_W{1'b0}};
                        state_nxt_s   = EMIT;
                    end else begin
                        acc_nxt_s     = acc_r | flag_s;
                        row_cnt_nxt_s = row_cnt_r + RC_W'(1);
                    end
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            EMIT: begin
                if (mask_out_ready) begin
                    state_nxt_s = ACCUM;
                end else begin
                    state_nxt_s = EMIT;
                end
            end
            default: begin
                state_nxt_s   = ACCUM;
                acc_nxt_s     = {IN_SIZE{1'b0}};
                row_cnt_nxt_s = {RC_W{1'b0}};
            end
        endcase
    end

    // FSM, accumulator, row counter and held result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ACCUM;
            acc_r     <= {IN_SIZE{1'b0}};
            row_cnt_r <= {RC_W{1'b0}};
            mask_r    <= {IN_SIZE{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            valid_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            acc_r     <= acc_nxt_s;
            row_cnt_r <= row_cnt_nxt_s;
            mask_r    <= mask_nxt_s;
            count_r   <= count_nxt_s;
            valid_r   <= (state_nxt_s == EMIT);
        end
    end

    // Ready is gated by rst directly so no beat is taken while reset is held
    assign data_in_ready  = !rst && (state_r == ACCUM);
    assign mask_out       = mask_r;
    assign outlier_count  = count_r;
    assign mask_out_valid = valid_r;

endmodule : outlier_mask_scheduler
